// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Ports: none.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DPS  = 2'b01,
    LOAD = 2'b10
  } state_t;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_ENTRY_W    = 10;
  localparam int ENT_PERR       = 8;
  localparam int ENT_FERR       = 9;

  // The shift register holds {stop, parity, d7..d0}; the start bit is
  // checked on entry to DPS and never stored.
  function automatic logic [PS2_ENTRY_W-1:0] make_entry(input logic [9:0] frame);
    make_entry = {~frame[9], ~(^frame[8:0]), frame[7:0]};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word-fall-through FIFO for received PS/2 entries.
// Latency: a write is visible at head the cycle after; a pop shows the next head the cycle after.
// Backpressure: none upstream; a write while full is dropped (flagged) unless a pop happens in the same cycle.
// Ports: clk, reset (sync, active-high), wr/wdata push, rd pop, head/empty/full status,
//        dropped = this cycle's write was refused.
module ps2_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             dropped
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             pop;
  logic             push_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign pop     = rd & ~empty;
  // When full, a same-cycle pop frees the slot the write lands in
  // (wr_ptr == rd_ptr), so the write can be accepted.
  assign push_ok = wr & ((cnt < (AW+1)'(DEPTH)) | pop);
  assign dropped = wr & ~push_ok;
  // Head is forced to zero while empty so outputs read 0 out of reset.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ps2_rx_fifo_chk.sv
// PS/2 device-to-host receiver: clock filter, 11-bit deframer, parity/stop checks, watchdog, entry FIFO.
// Latency: rx_done_tick one cycle after the stop-bit fall; byte at head two cycles after it.
// Backpressure: rd_en drains the FIFO; frames arriving while full are dropped and flagged in overflow.
// Ports: reloj, reset (sync, active-high), ps2d/ps2c lines, rd_en pop, clr_err clears sticky flags;
//        dout/parity_err/frame_err head entry, empty/full, rx_done_tick, overflow, timeout.
module ps2_rx_fifo_chk
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       reloj,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] dout,
  output logic       parity_err,
  output logic       frame_err,
  output logic       empty,
  output logic       full,
  output logic       rx_done_tick,
  output logic       overflow,
  output logic       timeout
);

  localparam int WD_W = $clog2(TIMEOUT_CYC);

  logic [FILTER_LEN-1:0]  filt;
  logic                   f_val;
  logic                   f_val_next;
  logic                   fall_edge;
  state_t                 state;
  logic [3:0]             n_cnt;
  logic [9:0]             frame;
  logic [WD_W-1:0]        wd;
  logic                   wd_fire;
  logic                   push;
  logic                   drop;
  logic [PS2_ENTRY_W-1:0] head;

  // Filtered clock only changes once the whole window agrees.
  always_comb begin
    f_val_next = f_val;
    if (&filt)       f_val_next = 1'b1;
    else if (~|filt) f_val_next = 1'b0;
  end

  assign fall_edge = f_val & ~f_val_next;
  // A fall edge in the same cycle restarts the watchdog, so it wins.
  assign wd_fire   = (state == DPS) && !fall_edge && (wd == WD_W'(TIMEOUT_CYC - 1));
  assign push      = (state == LOAD);

  always_ff @(posedge reloj) begin
    if (reset) begin
      filt         <= '0;
      f_val        <= 1'b0;
      state        <= IDLE;
      n_cnt        <= '0;
      frame        <= '0;
      wd           <= '0;
      rx_done_tick <= 1'b0;
      timeout      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      filt         <= {ps2c, filt[FILTER_LEN-1:1]};
      f_val        <= f_val_next;
      rx_done_tick <= 1'b0;

      if (state != DPS || fall_edge) wd <= '0;
      else                           wd <= wd + 1'b1;

      case (state)
        IDLE: begin
          // A high start bit is simply ignored.
          if (fall_edge && !ps2d) begin
            n_cnt <= 4'(PS2_FRAME_BITS - 2);
            state <= DPS;
          end
        end
        DPS: begin
          if (fall_edge) begin
            frame <= {ps2d, frame[9:1]};
            if (n_cnt == '0) begin
              state        <= LOAD;
              rx_done_tick <= 1'b1;
            end else begin
              n_cnt <= n_cnt - 1'b1;
            end
          end else if (wd_fire) begin
            state <= IDLE;
          end
        end
        LOAD:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Set beats clear when both happen in one cycle.
      timeout  <= wd_fire | (timeout & ~clr_err);
      overflow <= drop | (overflow & ~clr_err);
    end
  end

  ps2_sync_fifo #(
    .WIDTH (PS2_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (reloj),
    .reset   (reset),
    .wr      (push),
    .wdata   (make_entry(frame)),
    .rd      (rd_en),
    .head    (head),
    .empty   (empty),
    .full    (full),
    .dropped (drop)
  );

  assign dout       = head[7:0];
  assign parity_err = head[ENT_PERR];
  assign frame_err  = head[ENT_FERR];

endmodule

// File: doc/ps2_rx_fifo_chk.md
# ps2_rx_fifo_chk

Parametrised PS/2 device-to-host receiver. It filters `ps2c` and deserialises 11-bit frames, then checks the start bit, odd parity and stop bit. A watchdog aborts stalled frames. Each received byte, with its error flags, goes into a small first-word-fall-through FIFO. It replaces the single-byte receiver between the keyboard pins and the scan-code decoder, so the decoder can drain bytes at its own pace.

## Interface
Parameters:
- `FILTER_LEN`, default 8: `ps2c` glitch-filter length in `reloj` cycles, 2..16.
- `FIFO_DEPTH`, default 4: number of FIFO entries; power of two, 2..16.
- `TIMEOUT_CYC`, default 100000: idle-clock cycles after which a frame in progress is aborted; must be greater than 1.

Ports (reset is synchronous and active-high; all logic runs on one clock, `reloj`):
- `reloj`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `ps2d`, `ps2c`  in  1  PS/2 data and clock lines, already synchronised.
- `rd_en`  in  1  pop the FIFO head; ignored when `empty`=1.
- `dout`  out  8  head data byte; reset value 0x00.
- `parity_err`  out  1  head entry failed odd parity; reset 0.
- `frame_err`  out  1  head entry had stop bit = 0; reset 0.
- `empty`  out  1  FIFO empty; reset 1.
- `full`  out  1  FIFO full; reset 0.
- `rx_done_tick`  out  1  one-cycle pulse per completed frame; reset 0.
- `overflow`  out  1  sticky: a frame was dropped because the FIFO was full; reset 0.
- `timeout`  out  1  sticky: a frame was aborted by the watchdog; reset 0.
- `clr_err`  in  1  clears `overflow` and `timeout`.

## Operation
- **Filter.** A `FILTER_LEN`-bit shift register samples `ps2c`. The filtered clock goes to 1 when all bits are 1 and to 0 when all bits are 0; otherwise it holds. `fall_edge` = filtered clock is 1 and its next value is 0. `ps2d` is sampled in the `fall_edge` cycle.
- **FSM states: IDLE, DPS, LOAD.**
  - IDLE: on `fall_edge` with `ps2d`=0, load bit counter = 9 and go to DPS. On `fall_edge` with `ps2d`=1 (bad start bit), stay in IDLE and discard.
  - DPS: each `fall_edge` shifts `ps2d` in LSB-first. The counter decrements. The `fall_edge` that arrives with counter = 0 shifts in the stop bit and moves to LOAD.
  - LOAD: for exactly one cycle, pulse `rx_done_tick`, push the entry and return to IDLE.
- **Checks.**
  - `parity_err` = NOT(XOR of the 8 data bits and the parity bit).
  - `frame_err` = NOT(stop bit).
  - Bytes with errors are still pushed, with their flags set.
- **Watchdog.** A counter is cleared in IDLE and on every `fall_edge`, and increments in DPS. When it reaches `TIMEOUT_CYC`-1, the FSM returns to IDLE, `timeout` is set, and nothing is pushed or pulsed.
- **FIFO push.**
  - Each entry is 10 bits: {`frame_err`, `parity_err`, data}.
  - A push is accepted when count < `FIFO_DEPTH`, or when `rd_en`=1 and the FIFO is not empty in the same cycle (count is then unchanged).
  - Otherwise the entry is dropped and `overflow` is set.
- **FIFO pop.** `rd_en` pops when the FIFO is not empty. Pointers are log2(`FIFO_DEPTH`) bits and wrap modulo the depth. Count is log2(`FIFO_DEPTH`)+1 bits.
- **Sticky flags.** If a set event and `clr_err` occur in the same cycle, set wins.
- **Reset.** Reset mid-frame returns to IDLE with the FIFO emptied, the filter cleared to 0 and all sticky flags at 0. A partial frame is discarded.

## Timing
- `ps2c` must be low for `FILTER_LEN` consecutive samples before `fall_edge` is raised, and high for `FILTER_LEN` samples before the next fall can be detected.
- From the stop-bit `fall_edge` cycle (N):
  - LOAD in cycle N+1, with `rx_done_tick`=1 and the write at the end of N+1.
  - `empty` falls and `dout` is valid in cycle N+2.
- `rd_en` in cycle M: the next head (or `empty`=1) is visible in cycle M+1.
- `full` and `empty` are registered-count decodes with no combinational path from `rd_en`.
- The watchdog fires exactly `TIMEOUT_CYC` cycles after the last `fall_edge` or after entry to DPS.

## Structure
- Package `ps2_pkg`:
  - state enum {IDLE, DPS, LOAD} encoded 2'b00, 2'b01, 2'b10;
  - `PS2_FRAME_BITS`=11;
  - `PS2_ENTRY_W`=10;
  - field offsets `ENT_PERR`=8 and `ENT_FERR`=9.
- Sub-module `ps2_sync_fifo` (parameters `WIDTH`, `DEPTH`): FWFT with simultaneous push/pop when full as specified above. The top level instantiates it with `WIDTH`=10 and `DEPTH`=`FIFO_DEPTH`.

## Test plan
Frames are driven at a 40 µs bit period with a 50 MHz `reloj`, unless noted.
- **Valid frame:** frame 0x1C (bits 0, 0,0,1,1,1,0,0,0, parity 0, stop 1) -> one `rx_done_tick`; `dout`=0x1C with `parity_err`=0 and `frame_err`=0; `empty`=0 two cycles after the stop edge; `rd_en` -> `empty`=1.
- **Parity error:** 0x1C with parity bit 1 -> `parity_err`=1. 0xF0 with parity bit 1 -> `parity_err`=0.
- **Frame error:** stop bit 0 -> `frame_err`=1.
- **Bad start bit:** a frame with start bit 1 -> no push and no tick.
- **Overflow:** `FIFO_DEPTH`=4, five frames 0x01..0x05 with no reads -> `full`=1 and `overflow`=1. Reads return 0x01..0x04, then `empty`. `clr_err` -> `overflow`=0.
- **Push and pop together when full:** FIFO full, and `rd_en` asserted in the LOAD cycle of frame 0x06 -> `count` stays at 4, `overflow` stays at 0, and 0x06 is the last entry read out.
- **Timeout:** `TIMEOUT_CYC`=1000; start bit plus 3 bits, then `ps2c` held high -> `timeout`=1 exactly 1000 cycles after the 4th edge, no push. The following 0x5A frame is received correctly.
- **Glitch and reset:** 3-cycle low glitches on `ps2c` during a frame -> ignored, data correct. `reset` asserted after the 5th bit, then released -> `empty`=1, flags 0; the next full frame is decoded correctly.
